// File: rtl/vga_draw_pkg.sv
// ---------------------------------------------------------------------------
// vga_draw_pkg
// Shared definitions for the 160x120, 3-bit-colour VGA drawing subsystem.
// The arbiter and the drawing engines (clear, circle, ...) import this package.
//   H_RES_DEF / V_RES_DEF : default visible resolution
//   X_W / Y_W / COLOUR_W  : adapter bus widths
//   pixel_t               : one pixel write {x, y, colour}
//   on_screen()           : unsigned visibility test at full bus width
// ---------------------------------------------------------------------------
package vga_draw_pkg;

  localparam int unsigned H_RES_DEF = 160;
  localparam int unsigned V_RES_DEF = 120;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 7;
  localparam int unsigned COLOUR_W  = 3;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  // Coordinates are zero-extended, so no x/y value is ever treated as negative.
  function automatic logic on_screen(input pixel_t p,
                                     input int unsigned h_res,
                                     input int unsigned v_res);
    return (32'(p.x) < h_res) && (32'(p.y) < v_res);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: rotates the request vector so that bit
// 'ptr' comes first, finds the first set bit, and maps it back to an index.
//   req       : request bits
//   ptr       : highest-priority index this cycle (must be < N)
//   grant     : one-hot grant, zero when no request
//   grant_idx : index of the granted request (0 when none)
//   grant_any : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [N-1:0]  rot;
  logic [IW-1:0] ofs;

  // rot[i] is the request that sits i places after the pointer.
  always_comb begin
    int src;
    rot = '0;
    for (int i = 0; i < N; i++) begin
      src = i + int'(ptr);
      if (src >= N) src = src - N;
      rot[i] = req[src[IW-1:0]];
    end
  end

  // Scan downward so the lowest offset (closest to the pointer) wins.
  always_comb begin
    ofs       = '0;
    grant_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        ofs       = IW'(i);
        grant_any = 1'b1;
      end
    end
  end

  always_comb begin
    int sum;
    sum = int'(ptr) + int'(ofs);
    if (sum >= N) sum = sum - N;
    grant_idx = grant_any ? IW'(sum) : '0;
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = grant_any && (grant_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/pixel_plot_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_plot_arbiter
// Shares the single pixel-write port of the VGA adapter among NUM_REQ drawing
// engines. Round-robin arbitration, optional per-requester lock for whole
// operations, off-screen pixel clipping with a saturating clip counter.
//   clk, rst          : clock, synchronous active-high reset
//   enable            : 0 = no grants, all state retained
//   req_valid/lock    : per-requester pixel offer / ownership request
//   req_x/y/colour    : packed per-requester pixel fields
//   req_ready         : one-hot grant (combinational)
//   x, y, colour, plot: registered pixel write to the adapter (latency 1)
//   owner_valid/id    : current lock owner
//   clip_count        : saturating count of discarded off-screen pixels
// ---------------------------------------------------------------------------
module pixel_plot_arbiter
  import vga_draw_pkg::*;
#(
  parameter int          NUM_REQ = 3,
  parameter int unsigned H_RES   = H_RES_DEF,
  parameter int unsigned V_RES   = V_RES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [X_W*NUM_REQ-1:0]       req_x,
  input  logic [Y_W*NUM_REQ-1:0]       req_y,
  input  logic [COLOUR_W*NUM_REQ-1:0]  req_colour,
  input  logic [NUM_REQ-1:0]           req_lock,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot,
  output logic                         owner_valid,
  output logic [2:0]                   owner_id,
  output logic [15:0]                  clip_count
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]      ptr_reg, ptr_next;
  logic [IW-1:0]      owner_id_reg;
  logic               owner_valid_reg;
  logic [15:0]        clip_count_reg;
  pixel_t             pix_reg;
  logic               plot_reg;

  pixel_t             req_pix [NUM_REQ];
  pixel_t             sel_pix;
  logic [NUM_REQ-1:0] owner_mask, pick_req, grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any, grant_ok, xfer;
  logic               lock_g, owner_lock, sel_visible;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_pix[gi].x      = req_x[X_W*gi +: X_W];
      assign req_pix[gi].y      = req_y[Y_W*gi +: Y_W];
      assign req_pix[gi].colour = req_colour[COLOUR_W*gi +: COLOUR_W];
      assign owner_mask[gi]     = owner_valid_reg && (owner_id_reg == IW'(gi));
    end
  endgenerate

  // While a lock is held only the owner may be picked, even if it is idle.
  assign pick_req = owner_valid_reg ? (req_valid & owner_mask) : req_valid;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req       (pick_req),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign grant_ok   = !rst && enable;
  assign req_ready  = grant_ok ? grant : '0;
  assign xfer       = grant_ok && grant_any;
  assign lock_g     = |(req_lock & grant);
  assign owner_lock = |(req_lock & owner_mask);

  always_comb begin
    sel_pix = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_pix = req_pix[i];
    end
  end

  assign sel_visible = on_screen(sel_pix, H_RES, V_RES);
  assign ptr_next    = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg         <= '0;
      owner_valid_reg <= 1'b0;
      owner_id_reg    <= '0;
      clip_count_reg  <= '0;
      pix_reg         <= '0;
      plot_reg        <= 1'b0;
    end else begin
      plot_reg <= xfer && sel_visible;
      if (xfer && sel_visible) pix_reg <= sel_pix;
      if (xfer && !sel_visible && clip_count_reg != 16'hFFFF)
        clip_count_reg <= clip_count_reg + 16'd1;

      // Pointer stays put while the port is owned so that round-robin resumes
      // from where it stood when the lock was taken.
      if (xfer && !owner_valid_reg && !lock_g) ptr_reg <= ptr_next;

      // Taking a lock needs a transfer; dropping it does not. An owner that
      // transfers with lock low writes its pixel and releases on the same edge.
      if (xfer && lock_g) begin
        owner_valid_reg <= 1'b1;
        owner_id_reg    <= grant_idx;
      end else if (owner_valid_reg && !owner_lock) begin
        owner_valid_reg <= 1'b0;
        owner_id_reg    <= '0;
      end
    end
  end

  assign x           = pix_reg.x;
  assign y           = pix_reg.y;
  assign colour      = pix_reg.colour;
  assign plot        = plot_reg;
  assign owner_valid = owner_valid_reg;
  assign owner_id    = 3'(owner_id_reg);
  assign clip_count  = clip_count_reg;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pixel_plot_arbiter
// Directed stimulus with hand-derived grants. Each accepted on-screen pixel is
// queued as an expected adapter write; a monitor on the falling edge pops and
// compares whenever plot is high and flags any write nobody expected.
// ---------------------------------------------------------------------------
module tb_pixel_plot_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable;
  logic [2:0]  req_valid, req_lock, req_ready;
  logic [23:0] req_x;
  logic [20:0] req_y;
  logic [8:0]  req_colour;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, owner_valid;
  logic [2:0]  owner_id;
  logic [15:0] clip_count;

  logic [7:0]  px [3];
  logic [6:0]  py [3];
  logic [2:0]  pc [3];

  assign req_x      = {px[2], px[1], px[0]};
  assign req_y      = {py[2], py[1], py[0]};
  assign req_colour = {pc[2], pc[1], pc[0]};

  pixel_plot_arbiter dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .req_lock(req_lock), .req_ready(req_ready),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .owner_valid(owner_valid), .owner_id(owner_id), .clip_count(clip_count)
  );

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   plots = 0;
  int   seq   = 0;
  int   p0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every adapter write must match the oldest expectation.
  always @(negedge clk) begin
    if (plot === 1'b1) begin
      plots++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL plot: unexpected write (%0d,%0d,%0d), want no write", x, y, colour);
      end else begin
        mon_e = sb.pop_front();
        if ({x, y, colour} !== mon_e) begin
          bad++;
          $display("FAIL pixel: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   x, y, colour, mon_e.x, mon_e.y, mon_e.c);
        end
      end
    end
  end

  // One cycle: drive, check the combinational grant, queue the expected write.
  task automatic cyc(input logic [2:0] v, input logic [2:0] lk, input logic en,
                     input logic [2:0] exp_rdy, input string name);
    req_valid = v;
    req_lock  = lk;
    enable    = en;
    @(negedge clk);
    chk({name, " ready"}, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i] && px[i] < 8'd160 && py[i] < 7'd120)
        sb.push_back({px[i], py[i], pc[i]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic auto_pix();
    seq++;
    for (int i = 0; i < 3; i++) begin
      px[i] = 8'((seq * 7 + i * 50) % 160);
      py[i] = 7'((seq * 5 + i * 30) % 120);
      pc[i] = 3'(seq + i);
    end
  endtask

  task automatic acyc(input logic [2:0] v, input logic [2:0] lk, input logic en,
                      input logic [2:0] exp_rdy, input string name);
    auto_pix();
    cyc(v, lk, en, exp_rdy, name);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b1;
    req_valid = 3'b111;
    req_lock  = 3'b000;
    @(negedge clk);
    chk("reset ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; req_valid = '0; req_lock = '0;
    for (int i = 0; i < 3; i++) begin px[i] = '0; py[i] = '0; pc[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset plot", 32'(plot), 0);
    chk("reset x", 32'(x), 0);
    chk("reset y", 32'(y), 0);
    chk("reset colour", 32'(colour), 0);
    chk("reset owner_valid", 32'(owner_valid), 0);
    chk("reset owner_id", 32'(owner_id), 0);
    chk("reset clip_count", 32'(clip_count), 0);
    rst = 1'b0;

    // Single request, latency 1.
    px[0] = 8'd10; py[0] = 7'd20; pc[0] = 3'd5;
    cyc(3'b001, 3'b000, 1'b1, 3'b001, "single");
    chk("single plot", 32'(plot), 1);
    chk("single x", 32'(x), 10);
    cyc(3'b000, 3'b000, 1'b1, 3'b000, "single idle");
    chk("single plot low", 32'(plot), 0);

    // Round-robin from pointer 0.
    do_reset();
    p0 = plots;
    for (int k = 0; k < 6; k++)
      acyc(3'b111, 3'b000, 1'b1, 3'(3'b001 << (k % 3)), "rr");
    cyc(3'b000, 3'b000, 1'b1, 3'b000, "rr idle");
    chk("rr plot count", 32'(plots - p0), 6);

    // Lock hold (pointer 0 after six grants).
    acyc(3'b111, 3'b010, 1'b1, 3'b001, "lock A");
    chk("lock no xfer owner", 32'(owner_valid), 0);
    acyc(3'b111, 3'b010, 1'b1, 3'b010, "lock take");
    chk("lock owner_valid", 32'(owner_valid), 1);
    chk("lock owner_id", 32'(owner_id), 1);
    acyc(3'b111, 3'b010, 1'b1, 3'b010, "lock keep");
    for (int k = 0; k < 3; k++)
      acyc(3'b101, 3'b010, 1'b1, 3'b000, "lock idle owner");
    acyc(3'b111, 3'b000, 1'b1, 3'b010, "lock release");
    chk("release owner_valid", 32'(owner_valid), 0);
    acyc(3'b101, 3'b000, 1'b1, 3'b100, "after release");

    // Clipping at the screen boundary.
    px[0] = 8'd160; py[0] = 7'd0;   pc[0] = 3'd1;
    cyc(3'b001, 3'b000, 1'b1, 3'b001, "clip x160");
    px[0] = 8'd0;   py[0] = 7'd120; pc[0] = 3'd2;
    cyc(3'b001, 3'b000, 1'b1, 3'b001, "clip y120");
    px[0] = 8'd159; py[0] = 7'd119; pc[0] = 3'd3;
    cyc(3'b001, 3'b000, 1'b1, 3'b001, "edge 159,119");
    cyc(3'b000, 3'b000, 1'b1, 3'b000, "clip idle");
    chk("clip_count 2", 32'(clip_count), 2);

    // Saturation: 65537 more clipped transfers.
    px[0] = 8'd200; py[0] = 7'd10;
    req_valid = 3'b001;
    repeat (65537) @(posedge clk);
    #1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("clip saturate", 32'(clip_count), 32'h0000FFFF);

    // Enable low.
    acyc(3'b111, 3'b000, 1'b0, 3'b000, "enable low");
    chk("enable low plot", 32'(plot), 0);

    // Enable low while an owner is held.
    do_reset();
    acyc(3'b010, 3'b010, 1'b1, 3'b010, "own1 take");
    acyc(3'b111, 3'b010, 1'b0, 3'b000, "own1 disabled");
    chk("own1 kept", 32'(owner_valid), 1);
    acyc(3'b111, 3'b010, 1'b1, 3'b010, "own1 resume");
    acyc(3'b000, 3'b000, 1'b1, 3'b000, "own1 drop");
    chk("own1 dropped", 32'(owner_valid), 0);

    // Reset while req0 owns the port (pointer moved to 2 first).
    acyc(3'b010, 3'b000, 1'b1, 3'b010, "ptr to 2");
    acyc(3'b001, 3'b001, 1'b1, 3'b001, "own0 take");
    chk("own0 owner_valid", 32'(owner_valid), 1);
    do_reset();
    chk("rst owner_valid", 32'(owner_valid), 0);
    chk("rst owner_id", 32'(owner_id), 0);
    acyc(3'b111, 3'b000, 1'b1, 3'b001, "rearbitrate");

    // Simultaneous release and transfer by owner 2.
    acyc(3'b010, 3'b000, 1'b1, 3'b010, "ptr to 2 again");
    acyc(3'b100, 3'b100, 1'b1, 3'b100, "own2 take");
    chk("own2 owner_id", 32'(owner_id), 2);
    px[2] = 8'd5; py[2] = 7'd5; pc[2] = 3'd7;
    cyc(3'b111, 3'b000, 1'b1, 3'b100, "own2 release");
    chk("own2 release plot", 32'(plot), 1);
    chk("own2 release colour", 32'(colour), 7);
    chk("own2 release owner_valid", 32'(owner_valid), 0);
    acyc(3'b111, 3'b000, 1'b1, 3'b100, "rr from 2");
    acyc(3'b111, 3'b000, 1'b1, 3'b001, "rr next");

    cyc(3'b000, 3'b000, 1'b1, 3'b000, "drain");
    cyc(3'b000, 3'b000, 1'b1, 3'b000, "drain");
    chk("scoreboard empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_plot_arbiter.md
Name: pixel_plot_arbiter

Overview:
- Shares the single pixel-write port of the 160x120, 3-bit-colour VGA frame-buffer adapter among NUM_REQ drawing engines (screen-clear engine, Bresenham circle engine, future line/fill engines).
- Uses round-robin arbitration with an optional per-requester lock, so one engine can own the port for a whole operation.
- Discards off-screen pixels and counts them.
- Sits between the drawing engines and the adapter's x/y/colour/plot inputs.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- H_RES, 160, horizontal resolution; pixels with x >= H_RES are clipped.
- V_RES, 120, vertical resolution; pixels with y >= V_RES are clipped.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  0 = issue no grants; state retained.
- req_valid  in  NUM_REQ  requester i offers a pixel.
- req_x  in  8*NUM_REQ  x of requester i in bits [8i+7:8i].
- req_y  in  7*NUM_REQ  y of requester i in bits [7i+6:7i].
- req_colour  in  3*NUM_REQ  colour of requester i in bits [3i+2:3i].
- req_lock  in  NUM_REQ  requester i requests exclusive ownership.
- req_ready  out  NUM_REQ  one-hot (or zero) grant; transfer occurs when valid & ready.
- x  out  8  pixel x to adapter.
- y  out  7  pixel y to adapter.
- colour  out  3  pixel colour to adapter.
- plot  out  1  one-cycle write strobe to adapter.
- owner_valid  out  1  a lock owner is currently held.
- owner_id  out  3  index of the lock owner (0 when none).
- clip_count  out  16  saturating count of clipped pixels.

Behaviour:
- Reset (rst=1 at a clk edge) forces all of the following:
  - plot=0, x=0, y=0, colour=0.
  - Round-robin pointer = 0.
  - owner_valid=0, owner_id=0.
  - clip_count=0.
  - Reset mid-lock drops ownership immediately.
- req_ready is combinational from current state and inputs:
  - All zero when rst=1 or enable=0.
  - If owner_valid: req_ready[owner_id] = req_valid[owner_id]; all other bits are 0, even while the owner idles.
  - Otherwise: the first i with req_valid[i]=1, searching pointer, pointer+1, ... mod NUM_REQ, gets ready=1.
- Throughput: at most one transfer per cycle. The adapter never back-pressures, so no stall path is needed.
- On a transfer from requester g:
  - Pointer <= (g+1) mod NUM_REQ, unless g is or becomes the lock owner, in which case the pointer is held.
  - If req_lock[g]=1: owner_valid <= 1 and owner_id <= g.
- Releasing ownership:
  - The owner deasserts req_lock → owner_valid <= 0 on that edge; arbitration resumes next cycle from the held pointer.
  - Lock asserted without a transfer does not create ownership.
- Output pipeline, latency 1:
  - A transfer in cycle N with x < H_RES and y < V_RES → in cycle N+1, plot=1 and x/y/colour carry the transferred values.
  - A clipped transfer is still accepted (ready=1), but plot=0 in N+1 and clip_count increments, saturating at 0xFFFF.
  - No transfer → plot=0 next cycle; x/y/colour hold their last values.
- Simultaneous lock release and transfer by the owner: the pixel is written and ownership is dropped on the same edge.
- enable=0 while an owner is held: ownership is retained and no grants are issued; on re-enable the owner continues.
- Bus widths are fixed by the adapter (8/7/3). Comparisons against H_RES/V_RES are unsigned at full port width.

Decomposition:
- Shared package vga_draw_pkg holds H_RES_DEF=160, V_RES_DEF=120, X_W=8, Y_W=7, COLOUR_W=3, and the pixel struct {x, y, colour}. The circle and clear engines import it as well.
- Sub-module rr_pick: combinational rotate/find-first-set/unrotate over NUM_REQ bits, given the pointer. It is reusable by later schedulers.
- Pointer, owner and clip counter registers, plus the output stage, live in the top module.

Test Plan:
- Reset then single request: req0 valid with (10,20,5) → req_ready=001 in that cycle; next cycle plot=1, x=10, y=20, colour=5; the following cycle plot=0.
- Round-robin: all three valid continuously for 6 cycles, no lock → grant order 0,1,2,0,1,2; plot high on 6 consecutive cycles.
- Lock hold:
  - req1 asserts lock and valid alongside req0/req2 → owner_id=1.
  - req1 drops valid for 3 cycles with lock still high → req_ready=000 for those cycles.
  - req1 releases lock on its final transfer → the next grant goes to req2.
- Clipping: transfers at (160,0), (0,120) and (159,119) → only (159,119) produces plot; clip_count=2. Forcing 65537 clipped pixels leaves clip_count=0xFFFF.
- Enable/reset: enable=0 with all valid → req_ready=000 and plot=0. Asserting rst while req0 owns the lock → next cycle owner_valid=0, pointer=0, and req0 must re-arbitrate.
- Simultaneous release and transfer: owner req2 transfers (5,5,7) with lock=0 on the same cycle → plot for (5,5,7) and owner_valid=0 on the same edge; the next grant is made round-robin from pointer=2.
